// File: rtl/unsat_clause_fifo_writer_pkg.sv
// unsat_clause_fifo_writer_pkg
//   Shared sizing defaults and FSM state encoding for the newly-unsat clause
//   FIFO writer and its storage array.
package unsat_clause_fifo_writer_pkg;

    localparam int DEF_NSAT                  = 3;
    localparam int DEF_LITERAL_ADDRESS_WIDTH = 12;
    localparam int DEF_CLAUSE_WIDTH          = DEF_NSAT * DEF_LITERAL_ADDRESS_WIDTH;
    localparam int DEF_FIFO_DEPTH            = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DRAIN   = 2'd2
    } wr_state_e;

endpackage

// File: rtl/unsat_clause_fifo_writer_fifo_mem.sv
// unsat_clause_fifo_writer_fifo_mem
//   DEPTH x WIDTH register array holding {last_flag, clause} entries.
//   Ports:
//     clk_i       clock
//     we_i        write enable, writes wdata_i at waddr_i
//     waddr_i     write address
//     wdata_i     entry data, MSB is the batch-last flag
//     set_last_i  set the last flag of the entry at set_addr_i
//     set_addr_i  address for the last-flag set
//     raddr_i     asynchronous read address
//     rdata_o     entry at raddr_i
module unsat_clause_fifo_writer_fifo_mem #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 37,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             set_last_i,
    input  logic [AW-1:0]    set_addr_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem [DEPTH];

    // The owner never asks for a write and a last-flag set on the same entry
    // in one cycle (write targets wr_ptr, set targets wr_ptr-1).
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
        if (set_last_i) begin
            mem[set_addr_i][WIDTH-1] <= 1'b1;
        end
    end

    assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/unsat_clause_fifo_writer.sv
// unsat_clause_fifo_writer
//   Producer end of the newly-unsat clause FIFO. Filters one flip batch of
//   clause-evaluator beats, keeps the clauses flagged newly unsat and presents
//   them fall-through (head-first) to the unsat clause selector, with a
//   per-entry batch-last flag.
//   Ports:
//     clk_i, rst_i    clock, synchronous active-high reset
//     flush_i         abort batch, empty FIFO, clear overflow
//     eval_*          evaluator beat stream (valid/ready, clause, unsat, last)
//     pop_i           selector consumed head entry
//     fifo_empty_o    no valid head entry
//     fifo_clause_o   head clause (0 when empty)
//     fifo_last_o     head is last entry of batch (0 when empty)
//     count_o         occupancy
//     batch_done_o    one-cycle pulse once a batch is fully delivered
//     overflow_o      sticky: a push was dropped because the FIFO was full
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   IDLE     | no batch open, waiting for the first beat
//   COLLECT  | batch open, accepting beats until the last one
//   DRAIN    | batch closed, beats stalled until its last entry is popped
module unsat_clause_fifo_writer
    import unsat_clause_fifo_writer_pkg::*;
#(
    parameter int NSAT                  = DEF_NSAT,
    parameter int LITERAL_ADDRESS_WIDTH = DEF_LITERAL_ADDRESS_WIDTH,
    parameter int FIFO_DEPTH            = DEF_FIFO_DEPTH
) (
    input  logic                                    clk_i,
    input  logic                                    rst_i,
    input  logic                                    flush_i,
    input  logic                                    eval_valid_i,
    output logic                                    eval_ready_o,
    input  logic [NSAT*LITERAL_ADDRESS_WIDTH-1:0]   eval_clause_i,
    input  logic                                    eval_unsat_i,
    input  logic                                    eval_last_i,
    input  logic                                    pop_i,
    output logic                                    fifo_empty_o,
    output logic [NSAT*LITERAL_ADDRESS_WIDTH-1:0]   fifo_clause_o,
    output logic                                    fifo_last_o,
    output logic [$clog2(FIFO_DEPTH):0]             count_o,
    output logic                                    batch_done_o,
    output logic                                    overflow_o
);

    localparam int CW = NSAT * LITERAL_ADDRESS_WIDTH;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;

    wr_state_e       state_q, state_d;
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [PW-1:0]   count, count_next;
    logic            overflow_q, done_q, done_evt;
    logic            empty, full;
    logic            accept, push_req, push, pop, retro_mark;
    logic [CW:0]     head_entry;
    logic            head_last;

    assign count = wr_ptr_q - rd_ptr_q;
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign eval_ready_o = (state_q != ST_DRAIN);
    assign accept       = eval_valid_i & eval_ready_o;
    assign push_req     = accept & eval_unsat_i;
    assign push         = push_req & ~full;
    assign pop          = pop_i & ~empty;

    // A last beat that does not land in the FIFO (not unsat, or dropped on
    // overflow) hands the batch-last flag to the newest stored entry so the
    // batch still terminates on the consumer side.
    assign retro_mark = accept & eval_last_i & ~push & ~empty;

    assign count_next = count + PW'(push) - PW'(pop);

    unsat_clause_fifo_writer_fifo_mem #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CW + 1),
        .AW    (AW)
    ) u_fifo_mem (
        .clk_i      (clk_i),
        .we_i       (push),
        .waddr_i    (wr_ptr_q[AW-1:0]),
        .wdata_i    ({eval_last_i, eval_clause_i}),
        .set_last_i (retro_mark),
        .set_addr_i (wr_ptr_q[AW-1:0] - AW'(1)),
        .raddr_i    (rd_ptr_q[AW-1:0]),
        .rdata_o    (head_entry)
    );

    assign head_last = head_entry[CW];

    always_comb begin
        state_d  = state_q;
        done_evt = 1'b0;
        case (state_q)
            ST_IDLE, ST_COLLECT: begin
                if (accept) begin
                    if (eval_last_i) begin
                        if (count_next != '0) begin
                            state_d = ST_DRAIN;
                        end else begin
                            state_d  = ST_IDLE;
                            done_evt = 1'b1;
                        end
                    end else begin
                        state_d = ST_COLLECT;
                    end
                end
            end
            ST_DRAIN: begin
                if (pop && head_last && (count_next == '0)) begin
                    state_d  = ST_IDLE;
                    done_evt = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_evt;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            if (push_req && full) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign fifo_empty_o  = empty;
    assign fifo_clause_o = empty ? '0 : head_entry[CW-1:0];
    assign fifo_last_o   = ~empty & head_last;
    assign count_o       = count;
    assign batch_done_o  = done_q;
    assign overflow_o    = overflow_q;

endmodule

// File: tb/tb_unsat_clause_fifo_writer.sv
module tb_unsat_clause_fifo_writer;

    localparam int CW = 36;

    logic          clk_i = 1'b0;
    logic          rst_i, flush_i, eval_valid_i, eval_unsat_i, eval_last_i, pop_i;
    logic [CW-1:0] eval_clause_i;
    logic          eval_ready_o, fifo_empty_o, fifo_last_o, batch_done_o, overflow_o;
    logic [CW-1:0] fifo_clause_o;
    logic [4:0]    count_o;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [CW-1:0] CL_A = 36'hA01_A02_A03;
    localparam logic [CW-1:0] CL_B = 36'hB01_B02_B03;
    localparam logic [CW-1:0] CL_C = 36'hC01_C02_C03;
    localparam logic [CW-1:0] CL_D = 36'hD01_D02_D03;
    localparam logic [CW-1:0] CL_E = 36'hE01_E02_E03;
    localparam logic [CW-1:0] CL_F = 36'hF01_F02_F03;
    localparam logic [CW-1:0] CL_G = 36'h101_102_103;
    localparam logic [CW-1:0] CL_X = 36'h201_202_203;
    localparam logic [CW-1:0] CL_Y = 36'h301_302_303;

    unsat_clause_fifo_writer dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .flush_i       (flush_i),
        .eval_valid_i  (eval_valid_i),
        .eval_ready_o  (eval_ready_o),
        .eval_clause_i (eval_clause_i),
        .eval_unsat_i  (eval_unsat_i),
        .eval_last_i   (eval_last_i),
        .pop_i         (pop_i),
        .fifo_empty_o  (fifo_empty_o),
        .fifo_clause_o (fifo_clause_o),
        .fifo_last_o   (fifo_last_o),
        .count_o       (count_o),
        .batch_done_o  (batch_done_o),
        .overflow_o    (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic beat(input logic [CW-1:0] c, input logic u, input logic l);
        eval_valid_i  = 1'b1;
        eval_clause_i = c;
        eval_unsat_i  = u;
        eval_last_i   = l;
        cycle();
        eval_valid_i  = 1'b0;
        eval_unsat_i  = 1'b0;
        eval_last_i   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_i = 1'b1; flush_i = 1'b0; eval_valid_i = 1'b0; eval_unsat_i = 1'b0;
        eval_last_i = 1'b0; pop_i = 1'b0; eval_clause_i = '0;
        repeat (3) cycle();
        rst_i = 1'b0;

        chk("rst_empty", fifo_empty_o, 1);
        chk("rst_count", count_o, 0);
        chk("rst_ready", eval_ready_o, 1);
        chk("rst_last", fifo_last_o, 0);
        chk("rst_clause", fifo_clause_o, 0);
        chk("rst_done", batch_done_o, 0);
        chk("rst_ovf", overflow_o, 0);

        // batch 1: unsat 1,0,1,1 -> A,C,D with last on D
        beat(CL_A, 1, 0);
        chk("b1_empty_fall", fifo_empty_o, 0);
        chk("b1_head_a0", fifo_clause_o, CL_A);
        beat(CL_B, 0, 0);
        beat(CL_C, 1, 0);
        beat(CL_D, 1, 1);
        chk("b1_count", count_o, 3);
        chk("b1_ready_drain", eval_ready_o, 0);
        chk("b1_head_a", fifo_clause_o, CL_A);
        chk("b1_last_a", fifo_last_o, 0);
        chk("b1_done_early", batch_done_o, 0);
        pop_i = 1'b1;
        cycle();
        chk("b1_head_c", fifo_clause_o, CL_C);
        chk("b1_last_c", fifo_last_o, 0);
        cycle();
        chk("b1_head_d", fifo_clause_o, CL_D);
        chk("b1_last_d", fifo_last_o, 1);
        chk("b1_done_d", batch_done_o, 0);
        cycle();
        pop_i = 1'b0;
        chk("b1_empty", fifo_empty_o, 1);
        chk("b1_done", batch_done_o, 1);
        chk("b1_clause0", fifo_clause_o, 0);
        cycle();
        chk("b1_done_pulse", batch_done_o, 0);
        chk("b1_ready_idle", eval_ready_o, 1);

        // batch 2: unsat 1,1,0 -> retro-mark F
        beat(CL_E, 1, 0);
        beat(CL_F, 1, 0);
        beat(CL_G, 0, 1);
        chk("b2_count", count_o, 2);
        chk("b2_ready", eval_ready_o, 0);
        chk("b2_head_e", fifo_clause_o, CL_E);
        chk("b2_last_e", fifo_last_o, 0);
        pop_i = 1'b1;
        cycle();
        chk("b2_head_f", fifo_clause_o, CL_F);
        chk("b2_last_f", fifo_last_o, 1);
        cycle();
        pop_i = 1'b0;
        chk("b2_empty", fifo_empty_o, 1);
        chk("b2_done", batch_done_o, 1);
        cycle();

        // batch 3: nothing unsat
        beat(CL_A, 0, 0);
        beat(CL_B, 0, 0);
        beat(CL_C, 0, 1);
        chk("b3_done", batch_done_o, 1);
        chk("b3_empty", fifo_empty_o, 1);
        chk("b3_ready", eval_ready_o, 1);
        chk("b3_count", count_o, 0);
        cycle();
        chk("b3_done_pulse", batch_done_o, 0);

        // push with pop on empty FIFO, then push+pop on nonempty, then flush
        pop_i = 1'b1;
        beat(CL_X, 1, 0);
        pop_i = 1'b0;
        chk("pp_empty", fifo_empty_o, 0);
        chk("pp_head_x", fifo_clause_o, CL_X);
        chk("pp_count1", count_o, 1);
        pop_i = 1'b1;
        beat(CL_Y, 1, 0);
        pop_i = 1'b0;
        chk("pp_count_same", count_o, 1);
        chk("pp_head_y", fifo_clause_o, CL_Y);
        for (int i = 0; i < 4; i++) beat(CL_A + CW'(i), 1, 0);
        chk("fl_count5", count_o, 5);
        flush_i = 1'b1;
        cycle();
        flush_i = 1'b0;
        chk("fl_empty", fifo_empty_o, 1);
        chk("fl_count", count_o, 0);
        chk("fl_ready", eval_ready_o, 1);
        chk("fl_done", batch_done_o, 0);
        cycle();
        chk("fl_done2", batch_done_o, 0);

        // reset mid-collect
        beat(CL_A, 1, 0);
        beat(CL_B, 1, 0);
        rst_i = 1'b1;
        cycle();
        rst_i = 1'b0;
        chk("mr_empty", fifo_empty_o, 1);
        chk("mr_count", count_o, 0);
        chk("mr_ready", eval_ready_o, 1);
        cycle();
        chk("mr_done", batch_done_o, 0);

        // overflow: 18 unsat beats, last on 18th, no pops
        for (int i = 0; i < 18; i++) begin
            beat(CW'(36'h100 + i), 1, (i == 17));
            if (i == 15) begin
                chk("ov_count16", count_o, 16);
                chk("ov_not_yet", overflow_o, 0);
            end
            if (i == 16) begin
                chk("ov_set", overflow_o, 1);
                chk("ov_count_hold", count_o, 16);
            end
        end
        chk("ov_ready", eval_ready_o, 0);
        chk("ov_count_end", count_o, 16);
        pop_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("ov_head%0d", i), fifo_clause_o, 64'(36'h100 + i));
            chk($sformatf("ov_last%0d", i), fifo_last_o, (i == 15) ? 1 : 0);
            cycle();
        end
        pop_i = 1'b0;
        chk("ov_empty", fifo_empty_o, 1);
        chk("ov_done", batch_done_o, 1);
        chk("ov_sticky", overflow_o, 1);
        cycle();
        chk("ov_done_pulse", batch_done_o, 0);
        flush_i = 1'b1;
        cycle();
        flush_i = 1'b0;
        chk("ov_flush_clr", overflow_o, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
